// File: rtl/div3_word_serializer_if.sv
// Word-in / bit-out bus of the divisible-by-3 word serializer.
//
// Handshake: the upstream side drives in_valid and in_data and holds them
// until a cycle where in_ready is also high; a word transfers on exactly those
// cycles (in_valid & in_ready at the rising clock edge). in_ready never depends
// on in_valid, so the upstream may wait for in_ready before raising in_valid
// or raise in_valid first -- both are legal. in_data is ignored on all other
// cycles.
//
// The bit side has no back-pressure: bit_out/bit_valid/bit_last describe one
// bit per cycle for the downstream detector, det_clr resets that detector and
// word_done marks the cycle in which the detector result covers a whole word.
// state_dbg mirrors the serializer FSM state for checkers and debug.
interface div3_word_serializer_if #(
  parameter int W = 8
);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         det_clr;
  logic         bit_out;
  logic         bit_valid;
  logic         bit_last;
  logic         word_done;
  logic         busy;
  logic [1:0]   state_dbg;

  // Upstream word source plus observer of the bit stream.
  modport master (
    output in_valid,
    output in_data,
    input  in_ready,
    input  det_clr,
    input  bit_out,
    input  bit_valid,
    input  bit_last,
    input  word_done,
    input  busy,
    input  state_dbg
  );

  // The serializer itself.
  modport slave (
    input  in_valid,
    input  in_data,
    output in_ready,
    output det_clr,
    output bit_out,
    output bit_valid,
    output bit_last,
    output word_done,
    output busy,
    output state_dbg
  );
endinterface

// File: rtl/div3_word_serializer.sv
// Word serializer feeding the serial divisible-by-3 detector.
//
// Each accepted W-bit word is preceded by one det_clr cycle and then sent
// MSB-first, one bit per cycle. A single holding register (pend) lets the
// upstream hand over the next word while the current one is shifting, so
// words run back-to-back at one word per W+1 cycles. word_done is a
// registered copy of bit_last: it lands in the cycle where the detector has
// absorbed bit 0 of the word. The W parameter must match the interface's W.
module div3_word_serializer #(
  parameter int W = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  div3_word_serializer_if.slave    bus
);

  localparam int CW = (W > 2) ? $clog2(W) : 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLR   = 2'd1,
    ST_SHIFT = 2'd2
  } state_e;

  // Registered state
  state_e         state_q,     state_d;
  logic [W-1:0]   shifter_q,   shifter_d;
  logic [CW-1:0]  count_q,     count_d;
  logic [W-1:0]   pend_q,      pend_d;
  logic           pend_full_q, pend_full_d;
  logic           word_done_q, word_done_d;

  // Combinational outputs
  logic           transfer;
  logic           det_clr;
  logic           bit_out;
  logic           bit_valid;
  logic           bit_last;

  // in_ready only looks at the registered pend flag, so there is no path
  // from in_valid back to in_ready.
  assign bus.in_ready = !pend_full_q;
  assign transfer     = bus.in_valid && !pend_full_q;

  // Next-state and output decode for the IDLE / CLR / SHIFT sequencer.
  always_comb begin
    state_d     = state_q;
    shifter_d   = shifter_q;
    count_d     = count_q;
    pend_d      = pend_q;
    pend_full_d = pend_full_q;
    word_done_d = 1'b0;
    det_clr     = 1'b0;
    bit_out     = 1'b0;
    bit_valid   = 1'b0;
    bit_last    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // Nothing in flight: a new word goes straight to the shifter, so
        // pend is never used from here.
        if (transfer) begin
          shifter_d = bus.in_data;
          state_d   = ST_CLR;
        end
      end

      ST_CLR: begin
        det_clr = 1'b1;
        count_d = CW'(W - 1);
        state_d = ST_SHIFT;
        // pend is always empty on entry to CLR, so the next word parks there.
        if (transfer) begin
          pend_d      = bus.in_data;
          pend_full_d = 1'b1;
        end
      end

      ST_SHIFT: begin
        bit_valid = 1'b1;
        bit_out   = shifter_q[W-1];
        shifter_d = {shifter_q[W-2:0], 1'b0};
        if (count_q == '0) begin
          // Final bit of the word: pick the next word without a gap.
          bit_last    = 1'b1;
          word_done_d = 1'b1;
          count_d     = '0;
          if (pend_full_q) begin
            shifter_d   = pend_q;
            pend_full_d = 1'b0;
            state_d     = ST_CLR;
          end else if (transfer) begin
            // A word offered right now bypasses pend entirely.
            shifter_d = bus.in_data;
            state_d   = ST_CLR;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          count_d = count_q - CW'(1);
          if (transfer) begin
            pend_d      = bus.in_data;
            pend_full_d = 1'b1;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State register with synchronous reset; a reset drops any word in flight
  // and any word waiting in pend.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      shifter_q   <= '0;
      count_q     <= '0;
      pend_q      <= '0;
      pend_full_q <= 1'b0;
      word_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      shifter_q   <= shifter_d;
      count_q     <= count_d;
      pend_q      <= pend_d;
      pend_full_q <= pend_full_d;
      word_done_q <= word_done_d;
    end
  end

  assign bus.det_clr   = det_clr;
  assign bus.bit_out   = bit_out;
  assign bus.bit_valid = bit_valid;
  assign bus.bit_last  = bit_last;
  assign bus.word_done = word_done_q;
  assign bus.busy      = (state_q != ST_IDLE) || pend_full_q;
  assign bus.state_dbg = state_q;

endmodule
